mpu_rate_seq: RTL
=================

// Module: mpu_rate_seq
// PURPOSE
//  - Next-generation MPU rate control for the SAMx4 core. Decodes the R rate field into four one-hot classes:
//    slow, address-dependent slow, address-dependent fast and fast.
//  - Address-dependent slow is resolved against NUM_WIN programmable address windows.
//  - Generates the MPU E/Q phase clocks from a phase counter whose period follows the committed rate class.
//  - Rate changes commit only on an MPU cycle boundary, so E/Q never carry a truncated or stretched phase.
// PARAMETERS
//  ADDR_W    16  MPU address width
//  NUM_WIN   2   number of slow address windows
//  SLOW_DIV  16  clk cycles per MPU cycle at slow rate; multiple of 4, >= FAST_DIV
//  FAST_DIV  8   clk cycles per MPU cycle at fast rate; multiple of 4, >= 4
//  PHASE_W   5   phase counter width; 2**PHASE_W >= SLOW_DIV
// PORTS
//  clk           in   1                 system clock; all state changes on posedge
//  rst_n         in   1                 synchronous reset, active low
//  R             in   2                 rate field from SAM control register
//  addr          in   ADDR_W            current MPU address
//  win_base      in   NUM_WIN*ADDR_W    window i base at [i*ADDR_W +: ADDR_W]
//  win_mask      in   NUM_WIN*ADDR_W    window i compare mask; 1 = bit compared
//  win_en        in   NUM_WIN           per-window enable
//  rate_slow     out  1                 committed class: R==00
//  rate_ad_slow  out  1                 committed class: R==01 and address hit a window
//  rate_ad_fast  out  1                 committed class: R==01 and no window hit
//  rate_fast     out  1                 committed class: R[1]==1
//  e             out  1                 MPU E clock
//  q             out  1                 MPU Q clock
//  cycle_end     out  1                 one-clk pulse on the last phase of each MPU cycle
//  rate_change   out  1                 one-clk pulse when the committed class differs from the previous class
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge) forces:
//      - phase = 0, committed class = slow (rate_slow=1, other rate_* = 0)
//      - e = q = cycle_end = rate_change = 0
//    Reset mid-cycle aborts the cycle; the first post-reset cycle is a full slow cycle.
//  - Window hit: hit_i = win_en[i] && ((addr ^ win_base_i) & win_mask_i) == 0. is_slow = OR of hit_i.
//    A window with mask = 0 and en = 1 matches every address.
//  - Next class, decoded each clk: R[1] gives fast; R==01 gives ad_slow if is_slow, else ad_fast; R==00 gives slow.
//  - div = SLOW_DIV for slow and ad_slow; div = FAST_DIV for ad_fast and fast. div is taken from the committed class.
//  - Phase counter runs 0..div-1, then wraps to 0.
//  - Commit point is the clk where phase == div-1.
//      - At the posedge ending that clk, the committed class loads the next-class decode and phase loads 0.
//      - R and addr are sampled only at this point; changes at any other time have no effect until the next commit.
//  - rate_* outputs are registered one-hot and change only at commit. Exactly one is high at all times.
//  - Outputs e, q and cycle_end are flops, loaded from next-state decode so they align with the phase register:
//      - e = 1 when phase is in [div/2, div-1]
//      - q = 1 when phase is in [div/4, 3*div/4-1]
//      - cycle_end = 1 when phase == div-1
//  - rate_change is high for the first clk of a cycle whose committed class differs from the prior cycle's class.
//    It fires even when both classes share the same div (e.g. slow to ad_slow).
//  - Boundary: if R changes on the same clk as the commit point, the value present at that clk is used
//    (sampled at that posedge).
//  - Boundary: a phase counter value >= div cannot occur; if it is reached, the next clk forces phase to 0
//    and treats it as a commit.
//  - No combinational path from inputs to outputs. Latency from R/addr to rate_*: 1 clk after the commit-point posedge.
// STRUCTURE
//  - Shared package sam_pkg: rate class enum RATE_SLOW=0, RATE_AD_SLOW=1, RATE_AD_FAST=2, RATE_FAST=3,
//    and the default SLOW_DIV/FAST_DIV constants.
//  - Sub-module slow_win_match (params ADDR_W, NUM_WIN): purely combinational window compare producing is_slow.
//  - Top level holds the class register, phase counter, and the e/q/cycle_end/rate_change flops.
// TESTING
//  1. Hold rst_n=0 for 3 clks, then release with R=00. Expect rate_slow=1; e period 16 clks, high 8;
//     q high 8, leading e by 4 clks; rate_change never pulses.
//  2. R=10 from reset. Expect the first cycle slow (16 clks); next cycle rate_fast=1 with rate_change for 1 clk;
//     e period 8, high 4.
//  3. R switches 00 to 11 at phase 3 of a slow cycle. Expect the cycle to complete all 16 clks;
//     rate_fast asserts only after cycle_end.
//  4. R=01, win0 base=0xC000, mask=0xC000, en=1. addr=0xD123 at commit gives ad_slow (16 clks);
//     addr=0x1234 gives ad_fast (8 clks); rate_change pulses on each switch.
//  5. Same setup as 4 with win_en=0. Expect ad_fast regardless of addr.
//  6. Running fast, pull rst_n low at phase 5 for 1 clk. Expect e=q=0 next clk, rate_slow=1,
//     and the following cycle a full 16 clks.

Source files
------------

// File: rtl/sam_pkg.sv
// Shared SAM rate-control types: rate class encoding, default dividers
// and the R-field class decode used by the MPU rate sequencer.
package sam_pkg;

  typedef enum logic [1:0] {
    RATE_SLOW    = 2'd0,
    RATE_AD_SLOW = 2'd1,
    RATE_AD_FAST = 2'd2,
    RATE_FAST    = 2'd3
  } rate_e;

  localparam int SAM_SLOW_DIV = 16;
  localparam int SAM_FAST_DIV = 8;

  function automatic rate_e decode_rate(input logic [1:0] r, input logic is_slow);
    if (r[1]) begin
      return RATE_FAST;
    end else if (r[0]) begin
      return is_slow ? RATE_AD_SLOW : RATE_AD_FAST;
    end else begin
      return RATE_SLOW;
    end
  endfunction

  function automatic logic uses_slow_div(input rate_e c);
    return (c == RATE_SLOW) || (c == RATE_AD_SLOW);
  endfunction

endpackage

// File: rtl/slow_win_match.sv
// Combinational compare of the MPU address against the programmable slow
// windows; a window with an all-zero mask matches every address.
module slow_win_match #(
  parameter int ADDR_W  = 16,
  parameter int NUM_WIN = 2
) (
  input  logic [ADDR_W-1:0]         addr,
  input  logic [NUM_WIN*ADDR_W-1:0] win_base,
  input  logic [NUM_WIN*ADDR_W-1:0] win_mask,
  input  logic [NUM_WIN-1:0]        win_en,
  output logic                      is_slow
);

  always_comb begin
    is_slow = 1'b0;
    for (int i = 0; i < NUM_WIN; i++) begin
      if (win_en[i] &&
          (((addr ^ win_base[i*ADDR_W +: ADDR_W]) & win_mask[i*ADDR_W +: ADDR_W]) == '0)) begin
        is_slow = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mpu_rate_seq.sv
// MPU rate sequencer: commits the decoded rate class only on an MPU cycle
// boundary and generates E/Q phase clocks from a phase counter.
module mpu_rate_seq
  import sam_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int NUM_WIN  = 2,
  parameter int SLOW_DIV = SAM_SLOW_DIV,
  parameter int FAST_DIV = SAM_FAST_DIV,
  parameter int PHASE_W  = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                R,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [NUM_WIN*ADDR_W-1:0] win_base,
  input  logic [NUM_WIN*ADDR_W-1:0] win_mask,
  input  logic [NUM_WIN-1:0]        win_en,
  output logic                      rate_slow,
  output logic                      rate_ad_slow,
  output logic                      rate_ad_fast,
  output logic                      rate_fast,
  output logic                      e,
  output logic                      q,
  output logic                      cycle_end,
  output logic                      rate_change
);

  function automatic logic [31:0] div_of(input rate_e c);
    return uses_slow_div(c) ? 32'(SLOW_DIV) : 32'(FAST_DIV);
  endfunction

  rate_e              class_q, class_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [3:0]         rate_oh_q, rate_oh_d;
  logic               e_q, e_d, q_q, q_d, ce_q, ce_d, rc_q, rc_d;
  logic               is_slow;
  logic               commit;
  logic [31:0]        cur_div, nxt_div, ph_ext;

  slow_win_match #(
    .ADDR_W  (ADDR_W),
    .NUM_WIN (NUM_WIN)
  ) u_win (
    .addr     (addr),
    .win_base (win_base),
    .win_mask (win_mask),
    .win_en   (win_en),
    .is_slow  (is_slow)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      class_q   <= RATE_SLOW;
      rate_oh_q <= 4'b0001;
      phase_q   <= '0;
      e_q       <= 1'b0;
      q_q       <= 1'b0;
      ce_q      <= 1'b0;
      rc_q      <= 1'b0;
    end else begin
      class_q   <= class_d;
      rate_oh_q <= rate_oh_d;
      phase_q   <= phase_d;
      e_q       <= e_d;
      q_q       <= q_d;
      ce_q      <= ce_d;
      rc_q      <= rc_d;
    end
  end

  // ">=" rather than "==" so an out-of-range phase recovers as a commit.
  always_comb begin
    cur_div   = div_of(class_q);
    commit    = (32'(phase_q) >= (cur_div - 32'd1));
    class_d   = class_q;
    rate_oh_d = rate_oh_q;
    rc_d      = 1'b0;
    phase_d   = phase_q + 1'b1;
    if (commit) begin
      class_d   = decode_rate(R, is_slow);
      rate_oh_d = 4'b0001 << class_d;
      rc_d      = (class_d != class_q);
      phase_d   = '0;
    end
    // E/Q/cycle_end decode the next phase so the flops line up with phase_q.
    nxt_div = div_of(class_d);
    ph_ext  = 32'(phase_d);
    e_d     = (ph_ext >= (nxt_div / 32'd2));
    q_d     = (ph_ext >= (nxt_div / 32'd4)) && (ph_ext < ((32'd3 * nxt_div) / 32'd4));
    ce_d    = (ph_ext == (nxt_div - 32'd1));
  end

  always_comb begin
    rate_slow    = rate_oh_q[RATE_SLOW];
    rate_ad_slow = rate_oh_q[RATE_AD_SLOW];
    rate_ad_fast = rate_oh_q[RATE_AD_FAST];
    rate_fast    = rate_oh_q[RATE_FAST];
    e            = e_q;
    q            = q_q;
    cycle_end    = ce_q;
    rate_change  = rc_q;
  end

endmodule
